// File: rtl/dma_rd_slice.sv
// -----------------------------------------------------------------------------
// dma_rd_slice
//
// Read-side slice engine of the DMA controller. While the DMA FSM holds
// dma_rd_slice_valid high, the engine latches the selected descriptor and
// splits it into AXI AR bursts. Each burst is limited by MAX_BURST_BEATS, by
// the 4 KB page boundary and by the read mode. A credit counter keeps at most
// MAX_OUTSTANDING bursts in flight without their last R beat. Once every
// issued burst has completed (r_last_done), dma_rd_slice_done pulses for one
// cycle. If valid drops mid-slice, the engine stops issuing and waits for the
// bursts already issued to complete. It then returns to IDLE without a done
// pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_desc_src_addr[n]       source address of descriptor n
//   csr_desc_num_bytes[n]      byte count of descriptor n
//   csr_desc_read_mode[n]      0 = increment, 1 = jump (one beat per AR)
//   csr_desc_read_jump_bytes[n] address stride used in jump mode
//   dma_rd_slice_idx/_valid    descriptor request from the DMA FSM
//   dma_rd_slice_done          one-cycle completion pulse
//   m_axi_ar*                  AXI read-address channel (INCR bursts only)
//   r_last_done                pulse: an R beat with rlast was accepted downstream
// -----------------------------------------------------------------------------
module dma_rd_slice #(
  parameter int DMA_ADDR_WIDTH  = 32,
  parameter int DMA_DATA_WIDTH  = 64,
  parameter int DMA_BYTES_WIDTH = 32,
  parameter int DMA_NUM_DESC    = 8,
  parameter int DESC_IDX_WIDTH  = $clog2(DMA_NUM_DESC),
  parameter int MAX_BURST_BEATS = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [DMA_NUM_DESC-1:0][DMA_ADDR_WIDTH-1:0]     csr_desc_src_addr,
  input  logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]    csr_desc_num_bytes,
  input  logic [DMA_NUM_DESC-1:0]                         csr_desc_read_mode,
  input  logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]    csr_desc_read_jump_bytes,
  input  logic [DESC_IDX_WIDTH-1:0]                       dma_rd_slice_idx,
  input  logic                                            dma_rd_slice_valid,
  output logic                                            dma_rd_slice_done,
  output logic [DMA_ADDR_WIDTH-1:0]                       m_axi_araddr,
  output logic [7:0]                                      m_axi_arlen,
  output logic [2:0]                                      m_axi_arsize,
  output logic [1:0]                                      m_axi_arburst,
  output logic                                            m_axi_arvalid,
  input  logic                                            m_axi_arready,
  input  logic                                            r_last_done
);

  localparam int BEAT_BYTES = DMA_DATA_WIDTH / 8;
  localparam int LSB        = $clog2(BEAT_BYTES);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  // Headroom so that offset + remaining + (B-1) cannot overflow.
  localparam int CALC_W     = DMA_BYTES_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_ADDR,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [DESC_IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [DMA_ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DMA_BYTES_WIDTH-1:0]   remaining_q, remaining_d;
  logic                         mode_q, mode_d;
  logic [DMA_BYTES_WIDTH-1:0]   jump_q, jump_d;
  logic [DMA_ADDR_WIDTH-1:0]    araddr_q, araddr_d;
  logic [7:0]                   arlen_q, arlen_d;
  logic [DMA_BYTES_WIDTH-1:0]   bytes_q, bytes_d;
  logic [DMA_ADDR_WIDTH-1:0]    next_addr_q, next_addr_d;
  logic                         abort_q, abort_d;
  logic [OUT_W-1:0]             outstanding_q, outstanding_d;

  // ---------------------------------------------------------------------------
  // Burst sizing for the current position (addr_q, remaining_q).
  // ---------------------------------------------------------------------------
  logic [LSB-1:0]               addr_off;
  logic [CALC_W-1:0]            need;
  logic [11:0]                  page_off;
  logic [12:0]                  to4k;
  logic [8:0]                   beats;
  logic [CALC_W-1:0]            span;
  logic [DMA_BYTES_WIDTH-1:0]   burst_bytes;
  logic [DMA_ADDR_WIDTH-1:0]    burst_next_addr;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    addr_off = addr_q[LSB-1:0];
    // Beats needed to cover the remaining bytes from the aligned beat start.
    need     = (CALC_W'(addr_off) + CALC_W'(remaining_q) + CALC_W'(BEAT_BYTES - 1)) >> LSB;
    // Beats left before the next 4 KB page, counted from the aligned start.
    page_off = addr_q[11:0] & ~12'(BEAT_BYTES - 1);
    to4k     = (13'd4096 - {1'b0, page_off}) >> LSB;

    beats = 9'(MAX_BURST_BEATS);
    if (need < CALC_W'(beats)) begin
      beats = 9'(need);
    end
    if (to4k < 13'(beats)) begin
      beats = 9'(to4k);
    end

    // An unaligned start loses the leading offset bytes of the first beat.
    span            = (CALC_W'(beats) << LSB) - CALC_W'(addr_off);
    burst_bytes     = (span < CALC_W'(remaining_q)) ? DMA_BYTES_WIDTH'(span) : remaining_q;
    burst_next_addr = addr_q + DMA_ADDR_WIDTH'(burst_bytes);

    if (mode_q) begin
      // Jump mode: one beat per AR, then stride by the jump distance.
      beats           = 9'd1;
      burst_bytes     = (remaining_q < DMA_BYTES_WIDTH'(BEAT_BYTES)) ?
                        remaining_q : DMA_BYTES_WIDTH'(BEAT_BYTES);
      burst_next_addr = addr_q + DMA_ADDR_WIDTH'(jump_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Slice FSM: next-state and datapath updates.
  // ---------------------------------------------------------------------------
  logic ar_hs;
  assign ar_hs = (state_q == S_ADDR) && m_axi_arready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    jump_d      = jump_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    bytes_d     = bytes_q;
    next_addr_d = next_addr_q;
    abort_d     = abort_q;

    unique case (state_q)
      S_IDLE: begin
        if (dma_rd_slice_valid) begin
          idx_d   = dma_rd_slice_idx;
          abort_d = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!dma_rd_slice_valid) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else begin
          // The descriptor CSRs are sampled only here.
          addr_d      = csr_desc_src_addr[idx_q];
          remaining_d = csr_desc_num_bytes[idx_q];
          mode_d      = csr_desc_read_mode[idx_q];
          jump_d      = csr_desc_read_jump_bytes[idx_q];
          state_d     = S_CALC;
        end
      end

      S_CALC: begin
        if (!dma_rd_slice_valid) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          // Refreshed every cycle spent waiting for credit; frozen once in ADDR.
          araddr_d    = addr_q;
          arlen_d     = 8'(beats - 9'd1);
          bytes_d     = burst_bytes;
          next_addr_d = burst_next_addr;
          if (outstanding_q < OUT_W'(MAX_OUTSTANDING)) begin
            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        // A presented AR is never withdrawn; an abort is seen back in CALC.
        if (m_axi_arready) begin
          addr_d      = next_addr_q;
          remaining_d = (remaining_q >= bytes_q) ? (remaining_q - bytes_q) : '0;
          state_d     = S_CALC;
        end
      end

      S_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = abort_q ? S_IDLE : S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outstanding-burst credit counter. A completion with nothing in flight is
  // ignored; an accept and a completion in the same cycle cancel out.
  // ---------------------------------------------------------------------------
  logic r_dec;
  assign r_dec = r_last_done && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs && !r_dec) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!ar_hs && r_dec) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      addr_q        <= '0;
      remaining_q   <= '0;
      mode_q        <= 1'b0;
      jump_q        <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      bytes_q       <= '0;
      next_addr_q   <= '0;
      abort_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      mode_q        <= mode_d;
      jump_q        <= jump_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      bytes_q       <= bytes_d;
      next_addr_q   <= next_addr_d;
      abort_q       <= abort_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops arvalid and done at once.
  assign m_axi_arvalid     = (state_q == S_ADDR);
  assign m_axi_araddr      = araddr_q;
  assign m_axi_arlen       = arlen_q;
  assign m_axi_arsize      = 3'(LSB);
  assign m_axi_arburst     = 2'b01;
  assign dma_rd_slice_done = (state_q == S_DONE);

endmodule

// File: tb/tb_dma_rd_slice.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_slice
//
// Self-checking bench for dma_rd_slice. A behavioural model expands each
// descriptor into the list of AR bursts it must produce. A single monitor,
// sampling on the falling edge, checks every AR handshake against that list.
// It also checks AR stability under backpressure, the credit limit and the
// legality of each done pulse. Directed cases pin the model and the DUT to
// literal burst values, and randomized descriptors exercise the rest.
// -----------------------------------------------------------------------------
module tb_dma_rd_slice;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 32;
  localparam int ND = 8;
  localparam int IW = 3;
  localparam int MB = 16;
  localparam int MO = 4;
  localparam int B  = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ND-1:0][AW-1:0] src;
  logic [ND-1:0][BW-1:0] nbytes;
  logic [ND-1:0]         mode;
  logic [ND-1:0][BW-1:0] jump;
  logic [IW-1:0]         sidx;
  logic                  svalid;
  logic                  done;
  logic [AW-1:0]         araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic                  r_last_done;

  dma_rd_slice #(
    .DMA_ADDR_WIDTH (AW),
    .DMA_DATA_WIDTH (DW),
    .DMA_BYTES_WIDTH(BW),
    .DMA_NUM_DESC   (ND),
    .DESC_IDX_WIDTH (IW),
    .MAX_BURST_BEATS(MB),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .csr_desc_src_addr       (src),
    .csr_desc_num_bytes      (nbytes),
    .csr_desc_read_mode      (mode),
    .csr_desc_read_jump_bytes(jump),
    .dma_rd_slice_idx        (sidx),
    .dma_rd_slice_valid      (svalid),
    .dma_rd_slice_done       (done),
    .m_axi_araddr            (araddr),
    .m_axi_arlen             (arlen),
    .m_axi_arsize            (arsize),
    .m_axi_arburst           (arburst),
    .m_axi_arvalid           (arvalid),
    .m_axi_arready           (arready),
    .r_last_done             (r_last_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  ar_t exp_q[$];
  ar_t act_log[$];
  int  outst     = 0;
  int  ar_cnt    = 0;
  int  done_cnt  = 0;
  bit  no_done   = 1'b0;
  bit  mon_en    = 1'b0;
  int  ar_pct    = 100;
  int  rl_pct    = 100;
  int  rl_budget = 32'h7fff_ffff;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected AR bursts for one descriptor, derived from byte ranges: a burst
  // starts at the aligned beat holding 'a' and ends at the earliest of the
  // max-burst limit, the next 4 KB page, or the end of the data.
  function automatic void model_slice(input logic [31:0] a0, input int unsigned nb,
                                      input bit jm, input int unsigned jp);
    longint a, rem, off, base, lim, page, nbeats;
    a   = a0;
    rem = nb;
    while (rem > 0) begin
      if (jm) begin
        exp_q.push_back('{addr: 32'(a), len: 8'd0});
        rem = rem - ((rem < B) ? rem : B);
        a   = (a + jp) % 64'h1_0000_0000;
      end else begin
        off    = a % B;
        base   = a - off;
        lim    = base + MB * B;
        page   = (a / 4096 + 1) * 4096;
        if (page < lim) lim = page;
        if (a + rem < lim) lim = a + rem;
        nbeats = (lim - base + B - 1) / B;
        exp_q.push_back('{addr: 32'(a), len: 8'(nbeats - 1)});
        rem = rem - (lim - a);
        a   = lim % 64'h1_0000_0000;
      end
    end
  endfunction

  // Input drivers change just after the rising edge; the monitor samples on
  // the falling edge, where inputs and outputs are both settled.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Random AR-ready and R-completion responder.
  always begin
    @(posedge clk);
    #1;
    arready = ($urandom_range(1, 100) <= ar_pct);
    if (rl_budget > 0 && outst > 0 && $urandom_range(1, 100) <= rl_pct) begin
      r_last_done = 1'b1;
      rl_budget--;
    end else begin
      r_last_done = 1'b0;
    end
  end

  // Compare process.
  logic        prev_v, prev_r, prev_done;
  logic [31:0] prev_a;
  logic [7:0]  prev_l;

  always @(negedge clk) begin
    ar_t e;
    if (!rst_n || !mon_en) begin
      prev_v    = 1'b0;
      prev_r    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("ar_hold_valid", arvalid, 1'b1);
        check("ar_hold_addr", araddr, prev_a);
        check("ar_hold_len", arlen, prev_l);
      end
      if (arvalid) begin
        check("ar_credit_limit", (outst < MO), 1'b1);
      end
      if (arvalid && arready) begin
        act_log.push_back('{addr: araddr, len: arlen});
        ar_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ar: got addr 0x%0h len %0d, want no burst", araddr, arlen);
        end else begin
          e = exp_q.pop_front();
          check("ar_addr", araddr, e.addr);
          check("ar_len", arlen, e.len);
        end
        check("ar_size", arsize, 3'd3);
        check("ar_burst", arburst, 2'b01);
        outst++;
      end
      if (r_last_done && outst > 0) outst--;
      if (done) begin
        done_cnt++;
        check("done_legal", (exp_q.size() == 0 && outst == 0 && !no_done && !prev_done), 1'b1);
      end
      prev_v    = arvalid;
      prev_r    = arready;
      prev_a    = araddr;
      prev_l    = arlen;
      prev_done = done;
    end
  end

  // Run one complete slice on descriptor idx and check its completion.
  task automatic run_slice(input int idx, input string name);
    int d0, lat;
    bit got;
    d0  = done_cnt;
    lat = 0;
    got = 1'b0;
    model_slice(src[idx], nbytes[idx], mode[idx], jump[idx]);
    sidx   = IW'(idx);
    svalid = 1'b1;
    for (int c = 0; c < 3000 && !got; c++) begin
      tick();
      if (lat == 0 && arvalid) lat = c + 1;
      if (done) got = 1'b1;
    end
    svalid = 1'b0;
    check({name, "_done_seen"}, got, 1'b1);
    if (nbytes[idx] != 0) check({name, "_first_ar_latency"}, lat, 3);
    tick(2);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_bursts_left"}, exp_q.size(), 0);
    check({name, "_outstanding"}, outst, 0);
  endtask

  task automatic wait_arvalid(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = arvalid;
    end
    check({name, "_arvalid_seen"}, seen, 1'b1);
  endtask

  task automatic set_desc(input int idx, input logic [31:0] a, input int unsigned nb,
                          input bit m, input int unsigned jp);
    src[idx]    = a;
    nbytes[idx] = nb;
    mode[idx]   = m;
    jump[idx]   = jp;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    rst_n       = 1'b0;
    svalid      = 1'b0;
    sidx        = '0;
    arready     = 1'b0;
    r_last_done = 1'b0;
    src         = '0;
    nbytes      = '0;
    mode        = '0;
    jump        = '0;

    #3;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_arlen", arlen, 8'h0);
    check("rst_done", done, 1'b0);
    check("rst_arsize", arsize, 3'd3);
    check("rst_arburst", arburst, 2'b01);
    tick(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Pin the model against hand-computed bursts.
    model_slice(32'h0000_0FF4, 40, 1'b0, 0);
    check("model_unaligned_n", exp_q.size(), 2);
    check("model_unaligned_0", exp_q[0], {32'h0000_0FF4, 8'd1});
    check("model_unaligned_1", exp_q[1], {32'h0000_1000, 8'd3});
    exp_q.delete();
    model_slice(32'h0000_2000, 20, 1'b1, 32'h100);
    check("model_jump_n", exp_q.size(), 3);
    check("model_jump_2", exp_q[2], {32'h0000_2200, 8'd0});
    exp_q.delete();

    // Increment, aligned.
    act_log.delete();
    set_desc(2, 32'h0000_1000, 256, 1'b0, 0);
    run_slice(2, "aligned");
    check("aligned_n", act_log.size(), 2);
    if (act_log.size() == 2) begin
      check("aligned_ar0", act_log[0], {32'h0000_1000, 8'd15});
      check("aligned_ar1", act_log[1], {32'h0000_1080, 8'd15});
    end

    // Unaligned across a 4 KB page.
    act_log.delete();
    set_desc(5, 32'h0000_0FF4, 40, 1'b0, 0);
    run_slice(5, "unaligned");
    check("unaligned_n", act_log.size(), 2);
    if (act_log.size() == 2) begin
      check("unaligned_ar0", act_log[0], {32'h0000_0FF4, 8'd1});
      check("unaligned_ar1", act_log[1], {32'h0000_1000, 8'd3});
    end

    // Jump mode.
    act_log.delete();
    set_desc(1, 32'h0000_2000, 20, 1'b1, 32'h100);
    run_slice(1, "jump");
    check("jump_n", act_log.size(), 3);
    if (act_log.size() == 3) begin
      check("jump_ar0", act_log[0], {32'h0000_2000, 8'd0});
      check("jump_ar1", act_log[1], {32'h0000_2100, 8'd0});
      check("jump_ar2", act_log[2], {32'h0000_2200, 8'd0});
    end

    // Zero-byte descriptor: no AR, still one done.
    act_log.delete();
    set_desc(3, 32'h0000_3000, 0, 1'b0, 0);
    run_slice(3, "zero");
    check("zero_n", act_log.size(), 0);

    // Credit limit with completions withheld.
    set_desc(4, 32'h0000_4000, 1024, 1'b0, 0);
    model_slice(src[4], nbytes[4], mode[4], jump[4]);
    a0 = ar_cnt;
    d0 = done_cnt;
    rl_budget = 0;
    sidx   = 3'd4;
    svalid = 1'b1;
    tick(40);
    check("credit_ar_count_4", ar_cnt - a0, 4);
    check("credit_arvalid_low", arvalid, 1'b0);
    rl_budget = 1;
    tick(10);
    check("credit_ar_count_5", ar_cnt - a0, 5);
    rl_budget = 32'h7fff_ffff;
    for (int c = 0; c < 500 && done_cnt == d0; c++) tick();
    svalid = 1'b0;
    tick(2);
    check("credit_done_count", done_cnt - d0, 1);
    check("credit_ar_total", ar_cnt - a0, 8);
    check("credit_bursts_left", exp_q.size(), 0);

    // Backpressure: arready low for 5 cycles of arvalid, accepted on the 6th.
    set_desc(6, 32'h0000_6000, 64, 1'b0, 0);
    model_slice(src[6], nbytes[6], mode[6], jump[6]);
    a0 = ar_cnt;
    d0 = done_cnt;
    ar_pct = 0;
    sidx   = 3'd6;
    svalid = 1'b1;
    wait_arvalid("bp");
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_arvalid", arvalid, 1'b1);
      check("bp_araddr", araddr, 32'h0000_6000);
      check("bp_arlen", arlen, 8'd7);
    end
    check("bp_no_accept", ar_cnt - a0, 0);
    ar_pct = 100;
    tick();
    check("bp_arvalid_c6", arvalid, 1'b1);
    tick();
    check("bp_accepted", ar_cnt - a0, 1);
    for (int c = 0; c < 100 && done_cnt == d0; c++) tick();
    svalid = 1'b0;
    tick(2);
    check("bp_done_count", done_cnt - d0, 1);

    // Abort after the first AR.
    set_desc(0, 32'h0000_5000, 512, 1'b0, 0);
    model_slice(src[0], nbytes[0], mode[0], jump[0]);
    a0 = ar_cnt;
    d0 = done_cnt;
    rl_budget = 0;
    sidx   = 3'd0;
    svalid = 1'b1;
    wait_arvalid("abort");
    svalid  = 1'b0;
    no_done = 1'b1;
    tick(10);
    exp_q.delete();
    check("abort_ar_count", ar_cnt - a0, 1);
    check("abort_arvalid_low", arvalid, 1'b0);
    rl_budget = 1;
    tick(10);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_outstanding", outst, 0);
    no_done   = 1'b0;
    rl_budget = 32'h7fff_ffff;

    // Follow-up slice proves the engine went back to IDLE.
    act_log.delete();
    set_desc(7, 32'h0000_8010, 24, 1'b0, 0);
    run_slice(7, "post_abort");
    check("post_abort_ar0", act_log.size() == 1 ? act_log[0] : '0, {32'h0000_8010, 8'd2});

    // Reset asserted while an AR is presented.
    set_desc(6, 32'h0000_7000, 64, 1'b0, 0);
    model_slice(src[6], nbytes[6], mode[6], jump[6]);
    d0 = done_cnt;
    ar_pct = 0;
    sidx   = 3'd6;
    svalid = 1'b1;
    wait_arvalid("rst");
    rst_n = 1'b0;
    #1;
    check("rst_mid_arvalid", arvalid, 1'b0);
    check("rst_mid_araddr", araddr, 32'h0);
    check("rst_mid_arlen", arlen, 8'h0);
    svalid = 1'b0;
    exp_q.delete();
    outst = 0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("rst_mid_idle", arvalid, 1'b0);
    check("rst_mid_no_done", done_cnt - d0, 0);
    ar_pct = 100;

    // Randomized descriptors; iteration 0 wraps the address space.
    for (int it = 0; it < 40; it++) begin
      int sel;
      for (int d = 0; d < ND; d++) begin
        mode[d] = ($urandom_range(0, 2) == 0);
        if (mode[d]) begin
          src[d]    = $urandom & ~32'(B - 1);
          nbytes[d] = $urandom_range(0, 160);
          jump[d]   = $urandom_range(0, 32'h400) & ~32'(B - 1);
        end else begin
          src[d]    = $urandom;
          nbytes[d] = $urandom_range(0, 700);
          jump[d]   = $urandom;
        end
      end
      sel = $urandom_range(0, ND - 1);
      if (it == 0) set_desc(sel, 32'hFFFF_FFE4, 60, 1'b0, 0);
      ar_pct = $urandom_range(30, 100);
      rl_pct = $urandom_range(20, 100);
      run_slice(sel, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
